// File: rtl/ifid_pipe_buf.sv
// ifid_pipe_buf: small FIFO between instruction fetch and decode.
// Holds up to DEPTH fetched instructions with their PCs. It presents the
// oldest one to decode and drops everything on a branch/redirect flush,
// counting how many valid entries were thrown away.
//
// Handshake: a word moves on a rising edge only when its valid and ready
// are both high in that cycle. in_ready depends on registered occupancy
// only, never on out_ready. out_valid depends on registered occupancy only.
// The source must hold in_valid/in_instr/in_pc until it sees in_ready.
// flush wins over both transfers in the cycle where it is asserted.
module ifid_pipe_buf #(
    parameter int                   INSTR_W  = 25,
    parameter int                   PC_W     = 8,
    parameter int                   DEPTH    = 2,
    parameter logic [INSTR_W-1:0]   NOP_WORD = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [INSTR_W-1:0]         out_opcode,
    output logic [PC_W-1:0]            out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [7:0]                 drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage is left uninitialised; the output mux hides it while empty.
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];
    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [PC_W-1:0]    pc_mem_d    [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [7:0]         drop_q,   drop_d;

    logic               push;
    logic               pop;
    logic [8:0]         drop_sum;

    // Handshake qualifiers and registered-state outputs.
    always_comb begin
        in_ready   = (count_q < FULL_CNT);
        out_valid  = (count_q != '0);
        push       = in_valid && in_ready && !flush;
        pop        = out_valid && out_ready && !flush;
        out_opcode = out_valid ? instr_mem_q[rd_ptr_q] : NOP_WORD;
        out_pc     = out_valid ? pc_mem_q[rd_ptr_q] : '0;
        occupancy  = count_q;
        drop_cnt   = drop_q;
    end

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        drop_sum = {1'b0, drop_q} + 9'(count_q);
        if (flush) begin
            // Empty flush adds zero, so drop_cnt is naturally unchanged.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end else begin
            // Power-of-two DEPTH lets the pointers wrap by overflow.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Next-state for storage: write the pushed word at the tail slot.
    always_comb begin
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        if (push) begin
            instr_mem_d[wr_ptr_q] = in_instr;
            pc_mem_d[wr_ptr_q]    = in_pc;
        end
    end

    // Control registers with synchronous active-low reset (overrides flush).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage registers, not reset.
    always_ff @(posedge clk) begin
        instr_mem_q <= instr_mem_d;
        pc_mem_q    <= pc_mem_d;
    end

endmodule

// File: tb/tb_ifid_pipe_buf.sv
// tb_ifid_pipe_buf: directed table of single-cycle vectors, then hand-written
// sequences for streaming with pointer wrap and drop counter saturation.
module tb_ifid_pipe_buf;

    localparam int INSTR_W = 25;
    localparam int PC_W    = 8;
    localparam int DEPTH   = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [INSTR_W-1:0]  in_instr = '0;
    logic [PC_W-1:0]     in_pc = '0;
    logic                in_ready;
    logic                flush = 1'b0;
    logic                out_valid;
    logic [INSTR_W-1:0]  out_opcode;
    logic [PC_W-1:0]     out_pc;
    logic                out_ready = 1'b0;
    logic [1:0]          occupancy;
    logic [7:0]          drop_cnt;

    int errors = 0;
    int checks = 0;

    ifid_pipe_buf #(
        .INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH), .NOP_WORD('0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_pc(in_pc), .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_opcode(out_opcode), .out_pc(out_pc),
        .out_ready(out_ready), .occupancy(occupancy), .drop_cnt(drop_cnt)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic               rst_n;
        logic               in_valid;
        logic [INSTR_W-1:0] in_instr;
        logic [PC_W-1:0]    in_pc;
        logic               flush;
        logic               out_ready;
        logic               e_valid;
        logic [INSTR_W-1:0] e_opcode;
        logic [PC_W-1:0]    e_pc;
        logic [1:0]         e_occ;
        logic               e_ready;
        logic [7:0]         e_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic iv, input logic [INSTR_W-1:0] ins,
                       input logic [PC_W-1:0] pc, input logic fl, input logic ordy,
                       input logic ev, input logic [INSTR_W-1:0] eop,
                       input logic [PC_W-1:0] epc, input logic [1:0] eocc,
                       input logic erdy, input logic [7:0] edrop);
        vec_t v;
        v.rst_n = r; v.in_valid = iv; v.in_instr = ins; v.in_pc = pc;
        v.flush = fl; v.out_ready = ordy; v.e_valid = ev; v.e_opcode = eop;
        v.e_pc = epc; v.e_occ = eocc; v.e_ready = erdy; v.e_drop = edrop;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: apply inputs after negedge, clock once, sample 1 time unit later
    task automatic drive(input logic r, input logic iv, input logic [INSTR_W-1:0] ins,
                         input logic [PC_W-1:0] pc, input logic fl, input logic ordy);
        @(negedge clk);
        rst_n = r; in_valid = iv; in_instr = ins; in_pc = pc;
        flush = fl; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [INSTR_W-1:0] eop,
                             input logic [PC_W-1:0] epc, input logic [1:0] eocc,
                             input logic erdy, input logic [7:0] edrop);
        check({tag, ".out_valid"},  32'(out_valid),  32'(ev));
        check({tag, ".out_opcode"}, 32'(out_opcode), 32'(eop));
        check({tag, ".out_pc"},     32'(out_pc),     32'(epc));
        check({tag, ".occupancy"},  32'(occupancy),  32'(eocc));
        check({tag, ".in_ready"},   32'(in_ready),   32'(erdy));
        check({tag, ".drop_cnt"},   32'(drop_cnt),   32'(edrop));
    endtask

    initial begin
        // r iv instr pc fl ordy | ev opcode pc occ rdy drop
        add(0, 0, 25'h0,       8'h00, 0, 0,  0, 25'h0,       8'h00, 0, 1, 0); // reset
        add(1, 1, 25'h0ABCDEF, 8'h10, 0, 0,  1, 25'h0ABCDEF, 8'h10, 1, 1, 0); // 1-cycle latency
        add(1, 0, 25'h0,       8'h00, 0, 1,  0, 25'h0,       8'h00, 0, 1, 0); // pop to empty
        add(1, 0, 25'h1234567, 8'h77, 0, 1,  0, 25'h0,       8'h00, 0, 1, 0); // out_ready while empty
        add(1, 1, 25'h0111111, 8'h21, 0, 0,  1, 25'h0111111, 8'h21, 1, 1, 0); // push A
        add(1, 1, 25'h0222222, 8'h22, 0, 0,  1, 25'h0111111, 8'h21, 2, 0, 0); // push B -> full
        add(1, 1, 25'h0333333, 8'h23, 0, 0,  1, 25'h0111111, 8'h21, 2, 0, 0); // C ignored when full
        add(1, 1, 25'h0333333, 8'h23, 0, 1,  1, 25'h0222222, 8'h22, 1, 1, 0); // pop A, C still refused
        add(1, 1, 25'h0333333, 8'h23, 0, 1,  1, 25'h0333333, 8'h23, 1, 1, 0); // push C + pop B
        add(1, 0, 25'h0,       8'h00, 0, 1,  0, 25'h0,       8'h00, 0, 1, 0); // pop C
        add(1, 1, 25'h0444444, 8'h30, 0, 0,  1, 25'h0444444, 8'h30, 1, 1, 0); // push D
        add(1, 1, 25'h0555555, 8'h31, 0, 0,  1, 25'h0444444, 8'h30, 2, 0, 0); // push E
        add(1, 1, 25'h1FFFFFF, 8'h32, 1, 0,  0, 25'h0,       8'h00, 0, 1, 2); // flush full + in_valid
        add(1, 0, 25'h0,       8'h00, 0, 1,  0, 25'h0,       8'h00, 0, 1, 2); // flush word absent
        add(1, 0, 25'h0,       8'h00, 1, 0,  0, 25'h0,       8'h00, 0, 1, 2); // flush while empty
        add(1, 1, 25'h0666666, 8'h40, 0, 0,  1, 25'h0666666, 8'h40, 1, 1, 2); // push G
        add(0, 1, 25'h0777777, 8'h41, 1, 1,  0, 25'h0,       8'h00, 0, 1, 0); // reset beats flush/push
        add(1, 1, 25'h0888888, 8'h50, 0, 0,  1, 25'h0888888, 8'h50, 1, 1, 0); // push J
        add(1, 1, 25'h0999999, 8'h51, 1, 1,  0, 25'h0,       8'h00, 0, 1, 1); // flush beats push+pop
        add(1, 1, 25'h0AAAAAA, 8'h52, 0, 0,  1, 25'h0AAAAAA, 8'h52, 1, 1, 1); // push after flush

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].in_valid, vecs[i].in_instr, vecs[i].in_pc,
                  vecs[i].flush, vecs[i].out_ready);
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_opcode,
                      vecs[i].e_pc, vecs[i].e_occ, vecs[i].e_ready, vecs[i].e_drop);
        end

        // Streaming: reset, then 10 words with out_ready=1; expected order queue.
        begin
            logic [INSTR_W-1:0] exp_q[$];
            drive(0, 0, '0, '0, 0, 0);
            for (int k = 1; k <= 10; k++) begin
                exp_q.push_back(INSTR_W'(k));
                drive(1, 1, INSTR_W'(k), PC_W'(8'h80 + k), 0, 1);
                check($sformatf("stream%0d.opcode", k), 32'(out_opcode), 32'(exp_q.pop_front()));
                check($sformatf("stream%0d.pc", k), 32'(out_pc), 32'(8'h80 + k));
                check($sformatf("stream%0d.occ", k), 32'(occupancy), 32'd1);
            end
            drive(1, 0, '0, '0, 0, 1);
            check_all("stream_drain", 0, '0, '0, 0, 1, 0);
        end

        // Drop counter saturation: 130 flushes of a full buffer.
        begin
            int exp_drop;
            exp_drop = 0;
            for (int f = 1; f <= 130; f++) begin
                drive(1, 1, INSTR_W'(f), PC_W'(f), 0, 0);
                drive(1, 1, INSTR_W'(f + 1000), PC_W'(f), 0, 0);
                if (f == 1 || f == 130) check($sformatf("sat%0d.occ", f), 32'(occupancy), 32'd2);
                drive(1, 0, '0, '0, 1, 0);
                exp_drop = (exp_drop + 2 > 255) ? 255 : exp_drop + 2;
                check($sformatf("sat%0d.drop", f), 32'(drop_cnt), 32'(exp_drop));
            end
            check_all("sat_final", 0, '0, '0, 0, 1, 8'd255);
            // Reset mid-operation clears drop_cnt and does not add occupancy.
            drive(1, 1, 25'h0BBBBBB, 8'h60, 0, 0);
            drive(0, 0, '0, '0, 0, 0);
            check_all("reset_mid", 0, '0, '0, 0, 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/ifid_pipe_buf.md
IFID_PIPE_BUF -- requirements
Module: ifid_pipe_buf

Interface
REQ-001 SHALL have parameter INSTR_W, default 25, instruction word width in bits.
REQ-002 SHALL have parameter PC_W, default 8, fetch address width in bits.
REQ-003 SHALL have parameter DEPTH, default 2, buffer entries; legal values are 2, 4 and 8.
REQ-004 SHALL have parameter NOP_WORD, default all zeros, width INSTR_W, word driven when empty.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-007 in_valid  input  1  fetch stage offers an instruction.
REQ-008 in_instr  input  INSTR_W  fetched instruction word.
REQ-009 in_pc  input  PC_W  address of in_instr.
REQ-010 in_ready  output  1  buffer can accept this cycle.
REQ-011 flush  input  1  discard all buffered instructions (branch/redirect).
REQ-012 out_valid  output  1  out_opcode/out_pc hold a valid instruction.
REQ-013 out_opcode  output  INSTR_W  head instruction to decode.
REQ-014 out_pc  output  PC_W  address of head instruction.
REQ-015 out_ready  input  1  decode consumes head this cycle.
REQ-016 occupancy  output  $clog2(DEPTH)+1  number of valid entries.
REQ-017 drop_cnt  output  8  count of valid entries discarded by flush, saturating.

Function
REQ-018 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-019 in_ready SHALL be (occupancy < DEPTH), a function of registered state only, with no combinational path from out_ready.
REQ-020 out_valid SHALL be (occupancy != 0); out_opcode/out_pc SHALL present the oldest entry, driven from registered storage.
REQ-021 When empty, out_opcode SHALL equal NOP_WORD and out_pc SHALL equal 0.
REQ-022 Latency SHALL be one cycle: an instruction pushed at edge N is visible at the outputs after edge N, provided the buffer was empty.
REQ-023 Order SHALL be strict FIFO; no reordering or duplication.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged and SHALL write the new entry behind the remaining ones.
REQ-025 When full (occupancy == DEPTH), in_ready SHALL be 0; an in_valid offered while full SHALL be ignored, and the source holds it.
REQ-026 Pop while empty SHALL be impossible (out_valid=0); out_ready while empty SHALL have no effect.
REQ-027 Read/write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-028 flush SHALL take priority over push and pop: next cycle occupancy=0, pointers=0, out_valid=0, and the same-cycle in_valid word is discarded.
REQ-029 On flush, drop_cnt SHALL add the pre-flush occupancy, saturating at 255.
REQ-030 flush asserted while empty SHALL leave drop_cnt unchanged.

Reset
REQ-031 When rst_n=0 at a rising edge: occupancy=0, pointers=0, drop_cnt=0, out_valid=0, out_opcode=NOP_WORD, out_pc=0, in_ready=1 after that edge.
REQ-032 Reset SHALL override flush, push and pop in the same cycle.
REQ-033 Reset mid-operation SHALL discard all entries without incrementing drop_cnt.
REQ-034 Storage array contents need not be cleared by reset; no output SHALL expose them while empty.

Verification (DEPTH=2, INSTR_W=25, PC_W=8, NOP_WORD=0)
REQ-035 Push 0x0ABCDEF/pc 0x10 with out_ready=0 -> next cycle out_valid=1, out_opcode=0x0ABCDEF, out_pc=0x10, occupancy=1, in_ready=1.
REQ-036 Push A, B with out_ready=0, then offer C -> occupancy=2, in_ready=0, C not accepted; raise out_ready -> outputs A, then B, then C once re-offered.
REQ-037 Continuous push/pop with out_ready=1 for 10 words 0x1..0xA -> occupancy stays 1, output order 0x1..0xA, pointers wrap with no loss.
REQ-038 Fill 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, out_opcode=0, occupancy=0, drop_cnt=2, flush-cycle word absent.
REQ-039 Fill 1 entry, assert rst_n=0 together with flush and in_valid -> next cycle all outputs at reset values, drop_cnt=0.
REQ-040 Perform 130 flushes at occupancy 2 -> drop_cnt saturates at 255, with no wrap to 0.
